// File: rtl/csr_timer.sv
// Timer and stable-counter unit beside the CSR file: TID/TCFG/TVAL/TICLR registers,
// a countdown timer with a sticky interrupt level, and a 64-bit free-running counter.
module csr_timer #(
    parameter logic [31:0] TID_INIT = 32'h0,
    parameter int          TIMER_W  = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_we,
    input  logic [13:0] csr_num,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    output logic        timer_rhit,
    output logic [31:0] timer_rvalue,
    output logic        timer_int,
    output logic [31:0] stable_cnt_lo,
    output logic [31:0] stable_cnt_hi,
    output logic [31:0] tid_value
);

    localparam logic [13:0]        CSR_TID   = 14'h40;
    localparam logic [13:0]        CSR_TCFG  = 14'h41;
    localparam logic [13:0]        CSR_TVAL  = 14'h42;
    localparam logic [13:0]        CSR_TICLR = 14'h44;
    localparam logic [TIMER_W-1:0] CNT_IDLE  = '1;

    logic [31:0]        tid_q, tid_d;
    logic [31:0]        tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] timerCnt_q, timerCnt_d;
    logic               timerInt_q, timerInt_d;
    logic [63:0]        stableCnt_q, stableCnt_d;

    logic        tidWrite;
    logic        tcfgWrite;
    logic        ticlrClear;
    logic        timerExpire;
    logic [31:0] tidMerged;
    logic [31:0] tcfgMerged;
    logic [31:0] reloadValue;

    assign tidWrite    = csr_we && (csr_num == CSR_TID);
    assign tcfgWrite   = csr_we && (csr_num == CSR_TCFG);
    assign ticlrClear  = csr_we && (csr_num == CSR_TICLR) && csr_wmask[0] && csr_wvalue[0];
    assign tidMerged   = (csr_wmask & csr_wvalue) | (~csr_wmask & tid_q);
    assign tcfgMerged  = (csr_wmask & csr_wvalue) | (~csr_wmask & tcfg_q);
    assign reloadValue = {tcfg_q[31:2], 2'b00};

    // An expiry in the same cycle as a TCFG write is superseded by the write.
    assign timerExpire = tcfg_q[0] && (timerCnt_q == '0) && !tcfgWrite;

    always_comb begin
        tid_d       = tidWrite  ? tidMerged  : tid_q;
        tcfg_d      = tcfgWrite ? tcfgMerged : tcfg_q;
        timerCnt_d  = timerCnt_q;
        if (tcfgWrite) begin
            if (tcfgMerged[0]) begin
                timerCnt_d = {tcfgMerged[31:2], 2'b00};
            end
        end else if (timerExpire) begin
            timerCnt_d = tcfg_q[1] ? reloadValue : CNT_IDLE;
        end else if (tcfg_q[0] && (timerCnt_q != CNT_IDLE)) begin
            timerCnt_d = timerCnt_q - 1'b1;
        end
        timerInt_d  = timerExpire || (timerInt_q && !ticlrClear);
        stableCnt_d = stableCnt_q + 64'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tid_q       <= TID_INIT;
            tcfg_q      <= '0;
            timerCnt_q  <= CNT_IDLE;
            timerInt_q  <= 1'b0;
            stableCnt_q <= '0;
        end else begin
            tid_q       <= tid_d;
            tcfg_q      <= tcfg_d;
            timerCnt_q  <= timerCnt_d;
            timerInt_q  <= timerInt_d;
            stableCnt_q <= stableCnt_d;
        end
    end

    always_comb begin
        timer_rhit   = 1'b0;
        timer_rvalue = '0;
        case (csr_num)
            CSR_TID: begin
                timer_rhit   = 1'b1;
                timer_rvalue = tid_q;
            end
            CSR_TCFG: begin
                timer_rhit   = 1'b1;
                timer_rvalue = tcfg_q;
            end
            CSR_TVAL: begin
                timer_rhit   = 1'b1;
                timer_rvalue = timerCnt_q;
            end
            CSR_TICLR: begin
                timer_rhit   = 1'b1;
            end
            default: begin
                timer_rhit   = 1'b0;
            end
        endcase
    end

    assign timer_int     = timerInt_q;
    assign stable_cnt_lo = stableCnt_q[31:0];
    assign stable_cnt_hi = stableCnt_q[63:32];
    assign tid_value     = tid_q;

endmodule

// File: tb/tb_csr_timer.sv
// Scoreboard bench for csr_timer: stimulus pushes model predictions into a queue,
// an independent monitor pops one prediction per clock and compares the DUT outputs.
module tb_csr_timer;

    localparam logic [31:0] TID_INIT = 32'h1234_0005;

    logic        clk = 1'b0;
    logic        resetn;
    logic        csr_we = 1'b0;
    logic [13:0] csr_num = 14'h0;
    logic [31:0] csr_wmask = 32'h0;
    logic [31:0] csr_wvalue = 32'h0;
    logic        timer_rhit;
    logic [31:0] timer_rvalue;
    logic        timer_int;
    logic [31:0] stable_cnt_lo;
    logic [31:0] stable_cnt_hi;
    logic [31:0] tid_value;

    csr_timer #(.TID_INIT(TID_INIT), .TIMER_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .csr_we       (csr_we),
        .csr_num      (csr_num),
        .csr_wmask    (csr_wmask),
        .csr_wvalue   (csr_wvalue),
        .timer_rhit   (timer_rhit),
        .timer_rvalue (timer_rvalue),
        .timer_int    (timer_int),
        .stable_cnt_lo(stable_cnt_lo),
        .stable_cnt_hi(stable_cnt_hi),
        .tid_value    (tid_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        intr;
        logic        rhit;
        logic [31:0] rval;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [31:0] tid;
    } expT;

    expT expQ[$];
    expT monExp;
    int  checks = 0;
    int  fails  = 0;

    // Reference state: plain registers-as-numbers, updated once per clock edge.
    logic [31:0] mTid;
    logic [31:0] mCfg;
    logic [31:0] mCnt;
    logic        mInt;
    logic [63:0] mStable;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mTid    = TID_INIT;
        mCfg    = 32'h0;
        mCnt    = 32'hFFFF_FFFF;
        mInt    = 1'b0;
        mStable = 64'h0;
    endtask

    function automatic logic [32:0] readModel(input logic [13:0] num);
        case (num)
            14'h40:  return {1'b1, mTid};
            14'h41:  return {1'b1, mCfg};
            14'h42:  return {1'b1, mCnt};
            14'h44:  return {1'b1, 32'h0};
            default: return {1'b0, 32'h0};
        endcase
    endfunction

    task automatic stepAndPush(input logic we, input logic [13:0] num,
                               input logic [31:0] mask, input logic [31:0] val);
        logic [31:0] merged;
        logic [32:0] rd;
        bit          cfgWrite;
        bit          expire;
        bit          clear;
        expT         e;
        csr_we     = we;
        csr_num    = num;
        csr_wmask  = mask;
        csr_wvalue = val;
        cfgWrite = we && (num == 14'h41);
        clear    = we && (num == 14'h44) && mask[0] && val[0];
        expire   = mCfg[0] && (mCnt == 32'h0) && !cfgWrite;
        merged   = (mask & val) | (~mask & mCfg);
        if (cfgWrite) begin
            if (merged[0]) mCnt = merged & ~32'h3;
        end else if (expire) begin
            mCnt = mCfg[1] ? (mCfg & ~32'h3) : 32'hFFFF_FFFF;
        end else if (mCfg[0] && mCnt != 32'hFFFF_FFFF) begin
            mCnt = mCnt - 32'd1;
        end
        if (expire) mInt = 1'b1;
        else if (clear) mInt = 1'b0;
        if (we && num == 14'h40) mTid = (mask & val) | (~mask & mTid);
        if (cfgWrite) mCfg = merged;
        mStable = mStable + 64'd1;
        rd     = readModel(num);
        e.intr = mInt;
        e.rhit = rd[32];
        e.rval = rd[31:0];
        e.lo   = mStable[31:0];
        e.hi   = mStable[63:32];
        e.tid  = mTid;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input logic we, input logic [13:0] num,
                                 input logic [31:0] mask, input logic [31:0] val);
        @(negedge clk);
        stepAndPush(we, num, mask, val);
    endtask

    function automatic logic [13:0] pickNum();
        case ($urandom_range(0, 5))
            0:       return 14'h40;
            1:       return 14'h41;
            2:       return 14'h42;
            3:       return 14'h44;
            4:       return 14'h43;
            default: return 14'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, pickNum(), $urandom, $urandom);
    endtask

    task automatic idleUntilCnt(input logic [31:0] target, input int budget);
        int k;
        k = 0;
        while (mCnt != target && k < budget) begin
            applyStimulus(1'b0, 14'h42, 32'h0, 32'h0);
            k++;
        end
        if (mCnt != target) begin
            checks++;
            fails++;
            $display("[TB] FAIL wait_cnt: budget expired, count %h target %h", mCnt, target);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        #2 resetn = 1'b0;
        csr_we = 1'b0;
        modelReset();
        #1;
        checkOutput("rst_int", {31'b0, timer_int}, 32'h0);
        checkOutput("rst_lo", stable_cnt_lo, 32'h0);
        checkOutput("rst_hi", stable_cnt_hi, 32'h0);
        checkOutput("rst_tid", tid_value, TID_INIT);
        csr_num = 14'h42;
        #1 checkOutput("rst_tval", timer_rvalue, 32'hFFFF_FFFF);
        csr_num = 14'h41;
        #1 checkOutput("rst_tcfg", timer_rvalue, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        stepAndPush(1'b0, 14'h42, 32'h0, 32'h0);
    endtask

    task automatic backdoorCarry();
        @(negedge clk);
        force dut.stableCnt_q = 64'h0000_0000_FFFF_FFFE;
        #1 release dut.stableCnt_q;
        mStable = 64'h0000_0000_FFFF_FFFE;
        stepAndPush(1'b0, 14'h40, 32'h0, 32'h0);
    endtask

    always @(posedge clk) begin
        #1;
        if (resetn) begin
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("[TB] FAIL scoreboard: no prediction queued at %0t", $time);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("timer_int", {31'b0, timer_int}, {31'b0, monExp.intr});
                checkOutput("timer_rhit", {31'b0, timer_rhit}, {31'b0, monExp.rhit});
                checkOutput("timer_rvalue", timer_rvalue, monExp.rval);
                checkOutput("stable_lo", stable_cnt_lo, monExp.lo);
                checkOutput("stable_hi", stable_cnt_hi, monExp.hi);
                checkOutput("tid_value", tid_value, monExp.tid);
            end
        end
    end

    initial begin
        resetn = 1'b1;
        modelReset();
        #1 resetn = 1'b0;
        doReset();
        idle(3);

        // One-shot, InitVal=8: 32 down to 0, interrupt, then parked at all-ones.
        applyStimulus(1'b1, 14'h41, 32'hFFFF_FFFF, 32'h0000_0021);
        idleUntilCnt(32'h0, 60);
        idle(12);
        applyStimulus(1'b1, 14'h44, 32'hFFFF_FFFF, 32'h1);
        idle(2);

        // Periodic, InitVal=4: clear between expiries, then clear exactly at zero.
        applyStimulus(1'b1, 14'h41, 32'hFFFF_FFFF, 32'h0000_0013);
        idleUntilCnt(32'h0, 40);
        idleUntilCnt(32'h8, 40);
        applyStimulus(1'b1, 14'h44, 32'h1, 32'h1);
        idleUntilCnt(32'h0, 40);
        applyStimulus(1'b1, 14'h44, 32'hFFFF_FFFF, 32'h1);
        idle(20);

        // Masked TCFG write keeps En, reloads; TVAL writes are ignored.
        applyStimulus(1'b1, 14'h41, 32'hFFFF_FFFF, 32'h0000_0021);
        idle(5);
        applyStimulus(1'b1, 14'h41, 32'h2, 32'h0);
        applyStimulus(1'b0, 14'h42, 32'h0, 32'h0);
        applyStimulus(1'b1, 14'h42, 32'hFFFF_FFFF, 32'h1234);
        applyStimulus(1'b1, 14'h40, 32'h0000_FFFF, 32'hABCD_9876);
        idle(3);

        // InitVal=0: periodic fires every cycle, then one-shot fires once.
        applyStimulus(1'b1, 14'h41, 32'hFFFF_FFFF, 32'h3);
        idle(4);
        applyStimulus(1'b1, 14'h41, 32'hFFFF_FFFF, 32'h1);
        idle(4);

        // Disabling En stops the count but keeps a pending interrupt.
        applyStimulus(1'b1, 14'h41, 32'h1, 32'h0);
        idle(4);

        for (int i = 0; i < 500; i++) begin
            logic [31:0] val;
            logic [31:0] mask;
            val  = ($urandom_range(0, 1) == 1) ? ($urandom & 32'h3F) : $urandom;
            case ($urandom_range(0, 2))
                0:       mask = 32'hFFFF_FFFF;
                1:       mask = $urandom;
                default: mask = 32'h1;
            endcase
            applyStimulus($urandom_range(0, 3) == 0, pickNum(), mask, val);
        end

        backdoorCarry();
        idle(3);

        // Reset mid-countdown: counting must not resume without a new TCFG write.
        applyStimulus(1'b1, 14'h41, 32'hFFFF_FFFF, 32'h0000_0021);
        idle(10);
        doReset();
        idle(10);

        @(posedge clk);
        #2;
        if (expQ.size() != 0) begin
            checks++;
            fails++;
            $display("[TB] FAIL drain: %0d predictions left, expected 0", expQ.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
